// File: rtl/shift_sequencer.sv
// Multi-cycle logical shifter that applies one power-of-two stage per cycle over a single data register.
// Latency: start accepted at edge E gives done in cycle [E+AMT_W, E+AMT_W+1); one op every AMT_W+1 cycles.
// Backpressure: ready is low during SHIFT; a start seen while busy is dropped, not queued.
module shift_sequencer #(
  parameter int WIDTH = 64,
  parameter int AMT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             dir,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] shamt,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  // Stage counter only needs to index AMT_W stages.
  localparam int CTR_W = (AMT_W > 1) ? $clog2(AMT_W) : 1;
  localparam logic [CTR_W-1:0] LAST_STAGE = CTR_W'(AMT_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [AMT_W-1:0]   amt_q, amt_d;
  logic               dir_q, dir_d;
  logic [CTR_W-1:0]   stage_q, stage_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [AMT_W-1:0]   stage_amt;

  // Next-state, operand capture and one shift stage per SHIFT cycle.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    amt_d     = amt_q;
    dir_d     = dir_q;
    stage_d   = stage_q;
    // Stage k moves the operand by 2**k; k < AMT_W so this fits in AMT_W bits.
    stage_amt = AMT_W'(1) << stage_q;

    case (state_q)
      IDLE, DONE: begin
        // DONE behaves like IDLE for a new request, giving bubble-free back-to-back ops.
        if (start) begin
          data_d  = in_data;
          amt_d   = shamt;
          dir_d   = dir;
          stage_d = '0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (amt_q[stage_q]) begin
          data_d = dir_q ? (data_q >> stage_amt) : (data_q << stage_amt);
        end
        stage_d = stage_q + CTR_W'(1);
        // Always run every stage so latency never depends on the shift amount.
        if (stage_q == LAST_STAGE) begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    ready_d = (state_d != SHIFT);
    busy_d  = (state_d == SHIFT);
    done_d  = (state_d == DONE);
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      amt_q   <= '0;
      dir_q   <= 1'b0;
      stage_q <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      amt_q   <= amt_d;
      dir_q   <= dir_d;
      stage_q <= stage_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign ready  = ready_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = data_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: reset, latency, edge amounts, ignored start, back-to-back.
// Inputs driven 1ns after the rising edge; outputs sampled at the same offset.
// Every wait on done is bounded; a timeout shows up as a latency mismatch.
module tb_shift_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic        dir;
  logic [63:0] in_data;
  logic [5:0]  shamt;
  logic        ready;
  logic        busy;
  logic        done;
  logic [63:0] result;

  int n_checks;
  int n_fails;

  shift_sequencer #(.WIDTH(64), .AMT_W(6)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .dir     (dir),
    .in_data (in_data),
    .shamt   (shamt),
    .ready   (ready),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op; returns result at done, cycles from accept edge to done, and busy cycle count.
  // pulse_mid drives a second start (in_data=9) during the second SHIFT cycle.
  task automatic run_op(input logic [63:0] d, input logic [5:0] a, input logic dr,
                        input logic pulse_mid, output logic [63:0] res,
                        output int lat, output int bcnt);
    in_data = d;
    shamt   = a;
    dir     = dr;
    start   = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    // Scramble operands to show they were captured at the start edge.
    in_data = '1;
    shamt   = '1;
    dir     = ~dr;
    lat  = -1;
    bcnt = busy ? 1 : 0;
    for (int n = 1; n <= 20; n++) begin
      if (pulse_mid && n == 2) begin
        start   = 1'b1;
        in_data = 64'd9;
        shamt   = 6'd0;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (done) begin
        lat = n;
        break;
      end
      if (busy) bcnt++;
    end
    start = 1'b0;
    res   = result;
  endtask

  logic [63:0] res;
  int          lat;
  int          bcnt;
  int          dcnt;
  int          sep;

  logic [63:0] v_in  [6];
  logic [5:0]  v_amt [6];
  logic        v_dir [6];
  logic [63:0] v_exp [6];

  initial begin
    n_checks = 0;
    n_fails  = 0;
    start    = 1'b0;
    dir      = 1'b0;
    in_data  = '0;
    shamt    = '0;
    reset    = 1'b1;
    #2;
    check_eq("rst_ready",  64'(ready), 64'd1);
    check_eq("rst_busy",   64'(busy),  64'd0);
    check_eq("rst_done",   64'(done),  64'd0);
    check_eq("rst_result", result,     64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Reset during the second SHIFT cycle.
    in_data = 64'd5;
    shamt   = 6'd3;
    dir     = 1'b0;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_eq("mid_busy_before", 64'(busy), 64'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check_eq("mid_rst_ready",  64'(ready), 64'd1);
    check_eq("mid_rst_busy",   64'(busy),  64'd0);
    check_eq("mid_rst_done",   64'(done),  64'd0);
    check_eq("mid_rst_result", result,     64'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    check_eq("post_rst_idle_ready", 64'(ready), 64'd1);

    // Next op after reset runs normally: 5 << 3 = 40.
    run_op(64'd5, 6'd3, 1'b0, 1'b0, res, lat, bcnt);
    check_eq("post_rst_result", res, 64'd40);
    check_eq("post_rst_lat",    64'(lat), 64'd6);

    // Basic left shift, latency and busy width, then single-cycle done and held result.
    @(posedge clk); #1;
    run_op(64'd5, 6'd2, 1'b0, 1'b0, res, lat, bcnt);
    check_eq("left_result", res,        64'd20);
    check_eq("left_lat",    64'(lat),   64'd6);
    check_eq("left_busy",   64'(bcnt),  64'd6);
    check_eq("left_ready_in_done", 64'(ready), 64'd1);
    @(posedge clk); #1;
    check_eq("left_done_pulse", 64'(done),  64'd0);
    check_eq("left_idle_ready", 64'(ready), 64'd1);
    check_eq("left_hold",       result,     64'd20);

    // Edge amounts and right/overflow vectors.
    v_in[0] = 64'h8000_0000_0000_0001; v_amt[0] = 6'd0;  v_dir[0] = 1'b0; v_exp[0] = 64'h8000_0000_0000_0001;
    v_in[1] = 64'h0000_0000_0000_0001; v_amt[1] = 6'd63; v_dir[1] = 1'b0; v_exp[1] = 64'h8000_0000_0000_0000;
    v_in[2] = 64'h8000_0000_0000_0000; v_amt[2] = 6'd63; v_dir[2] = 1'b1; v_exp[2] = 64'h0000_0000_0000_0001;
    v_in[3] = 64'h7FFF_FFFF_FFFF_FFFF; v_amt[3] = 6'd4;  v_dir[3] = 1'b1; v_exp[3] = 64'h07FF_FFFF_FFFF_FFFF;
    v_in[4] = 64'h7FFF_FFFF_FFFF_FFFF; v_amt[4] = 6'd4;  v_dir[4] = 1'b0; v_exp[4] = 64'hFFFF_FFFF_FFFF_FFF0;
    v_in[5] = 64'h0000_0000_0000_00F0; v_amt[5] = 6'd3;  v_dir[5] = 1'b1; v_exp[5] = 64'h0000_0000_0000_001E;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      run_op(v_in[i], v_amt[i], v_dir[i], 1'b0, res, lat, bcnt);
      check_eq($sformatf("vec%0d_result", i), res,      v_exp[i]);
      check_eq($sformatf("vec%0d_lat", i),    64'(lat), 64'd6);
    end

    // Start during SHIFT is ignored and produces no second done.
    @(posedge clk); #1;
    run_op(64'd5, 6'd2, 1'b0, 1'b1, res, lat, bcnt);
    check_eq("ign_result", res,      64'd20);
    check_eq("ign_lat",    64'(lat), 64'd6);
    dcnt = 0;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk); #1;
      if (done) dcnt++;
    end
    check_eq("ign_no_second_done", 64'(dcnt), 64'd0);
    check_eq("ign_hold",           result,     64'd20);

    // Back-to-back: start held in DONE, second op accepted without a bubble.
    run_op(64'd5, 6'd2, 1'b0, 1'b0, res, lat, bcnt);
    check_eq("b2b_first_result", res,      64'd20);
    check_eq("b2b_first_lat",    64'(lat), 64'd6);
    in_data = 64'd3;
    shamt   = 6'd1;
    dir     = 1'b0;
    start   = 1'b1;
    #3;
    check_eq("b2b_first_held", result, 64'd20);
    sep = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (n == 1) check_eq("b2b_accepted_busy", 64'(busy), 64'd1);
      if (done) begin
        sep = n;
        break;
      end
    end
    check_eq("b2b_done_sep",      64'(sep), 64'd7);
    check_eq("b2b_second_result", result,   64'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
